vertex_stream_writer: RTL and testbench

// Producer end of the vertex FIFO. On i_start, walks an index buffer, fetches each

---
 rtl/vertex_stream_writer.sv | 148 ++++++++++++++
 tb/tb_vertex_stream_writer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_stream_writer.sv
// Producer end of the vertex FIFO: walks the index buffer, fetches each vertex,
// applies the viewport offset with 16-bit saturation and writes packed 104-bit words.
module vertex_stream_writer #(
  parameter int IDX_AW = 16,
  parameter int VTX_AW = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [15:0]       i_tri_count,
  input  logic [15:0]       i_off_x,
  input  logic [15:0]       i_off_y,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_idx_rd,
  output logic [IDX_AW-1:0] o_idx_addr,
  input  logic [15:0]       i_idx_data,
  output logic              o_vtx_rd,
  output logic [VTX_AW-1:0] o_vtx_addr,
  input  logic [15:0]       i_vtx_x,
  input  logic [15:0]       i_vtx_y,
  input  logic [7:0]        i_vtx_z,
  input  logic [31:0]       i_vtx_u,
  input  logic [31:0]       i_vtx_v,
  output logic              o_fifo_write,
  output logic [103:0]      o_fifo_data,
  input  logic              i_fifo_full,
  output logic [2:0]        o_dbg_state
);

  // FIFO handshake: a word is transferred on every rising edge where
  // o_fifo_write is high; o_fifo_write is only raised while i_fifo_full is low,
  // and o_fifo_data stays stable until that transfer happens.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IDX_RD   = 3'd1,
    S_IDX_DATA = 3'd2,
    S_VTX_RD   = 3'd3,
    S_VTX_DATA = 3'd4,
    S_PUSH     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t      state, state_n;
  logic [17:0] cnt3;
  logic [15:0] off_x, off_y;
  logic        busy_c, done_c, idx_rd_c, vtx_rd_c, write_c;
  logic        last_vertex;
  logic [16:0] sum_x, sum_y;
  logic        unused_idx_bits;

  assign unused_idx_bits = ^i_idx_data[15:VTX_AW];

  function automatic logic [15:0] sat16(input logic [16:0] s);
    if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7fff;
    return s[15:0];
  endfunction

  assign sum_x       = {i_vtx_x[15], i_vtx_x} + {off_x[15], off_x};
  assign sum_y       = {i_vtx_y[15], i_vtx_y} + {off_y[15], off_y};
  assign last_vertex = (18'(o_idx_addr) + 18'd1) == cnt3;

  always_comb begin
    state_n  = state;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    idx_rd_c = 1'b0;
    vtx_rd_c = 1'b0;
    write_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          busy_c  = 1'b1;
          state_n = (i_tri_count == 16'd0) ? S_DONE : S_IDX_RD;
        end
      end
      S_IDX_RD: begin
        busy_c   = 1'b1;
        idx_rd_c = 1'b1;
        state_n  = S_IDX_DATA;
      end
      S_IDX_DATA: begin
        busy_c  = 1'b1;
        state_n = S_VTX_RD;
      end
      S_VTX_RD: begin
        busy_c   = 1'b1;
        vtx_rd_c = 1'b1;
        state_n  = S_VTX_DATA;
      end
      S_VTX_DATA: begin
        busy_c  = 1'b1;
        state_n = S_PUSH;
      end
      S_PUSH: begin
        busy_c = 1'b1;
        if (!i_fifo_full) begin
          write_c = 1'b1;
          state_n = last_vertex ? S_DONE : S_IDX_RD;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Reset masks every combinational output so nothing fires in the reset cycle.
  assign o_busy       = busy_c   && !i_rst;
  assign o_done       = done_c   && !i_rst;
  assign o_idx_rd     = idx_rd_c && !i_rst;
  assign o_vtx_rd     = vtx_rd_c && !i_rst;
  assign o_fifo_write = write_c  && !i_rst;
  assign o_dbg_state  = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_idx_addr  <= '0;
      o_vtx_addr  <= '0;
      o_fifo_data <= '0;
      cnt3        <= '0;
      off_x       <= '0;
      off_y       <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            cnt3       <= 18'(i_tri_count) * 18'd3;
            off_x      <= i_off_x;
            off_y      <= i_off_y;
            o_idx_addr <= '0;
          end
        end
        S_IDX_DATA: o_vtx_addr <= i_idx_data[VTX_AW-1:0];
        S_VTX_DATA: o_fifo_data <= {sat16(sum_x), sat16(sum_y), i_vtx_z, i_vtx_u, i_vtx_v};
        S_PUSH: begin
          if (!i_fifo_full) o_idx_addr <= o_idx_addr + {{(IDX_AW-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_stream_writer.sv
// Bench for vertex_stream_writer: memory models, a queue-based scoreboard fed by a
// reference model of the index/vertex walk, and directed plus random runs.
module tb_vertex_stream_writer;
  localparam int IDX_AW = 16;
  localparam int VTX_AW = 12;
  localparam int W      = 104;
  localparam logic [2:0] ST_VTX_RD = 3'd3;
  localparam logic [2:0] ST_PUSH   = 3'd5;

  logic              i_clk, i_rst, i_start;
  logic [15:0]       i_tri_count, i_off_x, i_off_y;
  logic              o_busy, o_done, o_idx_rd, o_vtx_rd, o_fifo_write;
  logic [IDX_AW-1:0] o_idx_addr;
  logic [VTX_AW-1:0] o_vtx_addr;
  logic [15:0]       i_idx_data, i_vtx_x, i_vtx_y;
  logic [7:0]        i_vtx_z;
  logic [31:0]       i_vtx_u, i_vtx_v;
  logic [W-1:0]      o_fifo_data;
  logic              i_fifo_full;
  logic [2:0]        o_dbg_state;

  vertex_stream_writer #(.IDX_AW(IDX_AW), .VTX_AW(VTX_AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_tri_count(i_tri_count),
    .i_off_x(i_off_x), .i_off_y(i_off_y), .o_busy(o_busy), .o_done(o_done),
    .o_idx_rd(o_idx_rd), .o_idx_addr(o_idx_addr), .i_idx_data(i_idx_data),
    .o_vtx_rd(o_vtx_rd), .o_vtx_addr(o_vtx_addr), .i_vtx_x(i_vtx_x), .i_vtx_y(i_vtx_y),
    .i_vtx_z(i_vtx_z), .i_vtx_u(i_vtx_u), .i_vtx_v(i_vtx_v), .o_fifo_write(o_fifo_write),
    .o_fifo_data(o_fifo_data), .i_fifo_full(i_fifo_full), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // ---------------- memory models ----------------
  logic [15:0] idx_mem [0:255];
  logic [15:0] vx_mem  [0:4095];
  logic [15:0] vy_mem  [0:4095];
  logic [7:0]  vz_mem  [0:4095];
  logic [31:0] vu_mem  [0:4095];
  logic [31:0] vv_mem  [0:4095];

  initial forever begin
    @(posedge i_clk);
    if (o_idx_rd) i_idx_data <= idx_mem[o_idx_addr[7:0]];
    if (o_vtx_rd) begin
      i_vtx_x <= vx_mem[o_vtx_addr];
      i_vtx_y <= vy_mem[o_vtx_addr];
      i_vtx_z <= vz_mem[o_vtx_addr];
      i_vtx_u <= vu_mem[o_vtx_addr];
      i_vtx_v <= vv_mem[o_vtx_addr];
    end
  end

  // FIFO-full driver: forced high by the directed test or random back-pressure.
  logic full_force = 1'b0;
  logic full_mode  = 1'b0;
  initial begin
    i_fifo_full = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      i_fifo_full = full_force || (full_mode && ($urandom_range(0, 2) == 0));
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0]      exp_q[$];
  logic [IDX_AW-1:0] exp_idx_q[$];
  logic [VTX_AW-1:0] exp_vtx_q[$];
  logic [W-1:0]      got_q[$];
  int                wr_cyc_q[$];
  int n_checks = 0, n_fail = 0;
  int wr_cnt = 0, idx_rd_cnt = 0, vtx_rd_cnt = 0, done_cnt = 0, busy_cnt = 0, done_cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge i_clk);
    if (o_fifo_write) begin
      wr_cnt++;
      wr_cyc_q.push_back(cyc);
      got_q.push_back(o_fifo_data);
      check("write_while_full", i_fifo_full, 0);
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else check("fifo_data", o_fifo_data, exp_q.pop_front());
    end
    if (i_fifo_full && o_dbg_state == ST_PUSH && exp_q.size() > 0)
      check("hold_data", o_fifo_data, exp_q[0]);
    if (o_idx_rd) begin
      idx_rd_cnt++;
      if (exp_idx_q.size() == 0) check("unexpected_idx_rd", 1, 0);
      else check("idx_addr", o_idx_addr, exp_idx_q.pop_front());
    end
    if (o_vtx_rd) begin
      vtx_rd_cnt++;
      if (exp_vtx_q.size() == 0) check("unexpected_vtx_rd", 1, 0);
      else check("vtx_addr", o_vtx_addr, exp_vtx_q.pop_front());
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_in_done", o_busy, 0);
    end
    if (o_busy) busy_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] sat(input int s);
    if (s > 32767) return 16'h7fff;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  task automatic model_run(input int count, input logic [15:0] ox, input logic [15:0] oy);
    for (int t = 0; t < count * 3; t++) begin
      logic [15:0] idx;
      logic [VTX_AW-1:0] va;
      int sx, sy;
      idx = idx_mem[t[7:0]];
      va  = idx[VTX_AW-1:0];
      sx  = int'($signed(vx_mem[va])) + int'($signed(ox));
      sy  = int'($signed(vy_mem[va])) + int'($signed(oy));
      exp_idx_q.push_back(t[IDX_AW-1:0]);
      exp_vtx_q.push_back(va);
      exp_q.push_back({sat(sx), sat(sy), vz_mem[va], vu_mem[va], vv_mem[va]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input int count, input logic [15:0] ox, input logic [15:0] oy);
    model_run(count, ox, oy);
    i_tri_count = count[15:0];
    i_off_x = ox;
    i_off_y = oy;
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check({name, "_done_seen"}, done_cnt != d0, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_state(input logic [2:0] st, input int writes, input int budget,
                            input string name);
    int n;
    n = 0;
    while (!(o_dbg_state == st && wr_cnt == writes) && n < budget) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check(name, o_dbg_state == st && wr_cnt == writes, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int wr0, ir0, vr0, b0, d0, s0, cnt;
    i_rst = 1'b1; i_start = 1'b0; i_tri_count = '0; i_off_x = '0; i_off_y = '0;
    for (int a = 0; a < 4096; a++) begin
      vx_mem[a] = 16'($urandom); vy_mem[a] = 16'($urandom); vz_mem[a] = 8'($urandom);
      vu_mem[a] = $urandom; vv_mem[a] = $urandom;
    end
    for (int a = 0; a < 256; a++) idx_mem[a] = 16'($urandom);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_idx_addr", o_idx_addr, 0);
    check("rst_vtx_addr", o_vtx_addr, 0);
    check("rst_fifo_data", o_fifo_data, 0);
    check("rst_strobes", {o_idx_rd, o_vtx_rd, o_fifo_write}, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    cycles(2);

    // Basic triangle: spacing, latency and first x field.
    idx_mem[0] = 16'd0; idx_mem[1] = 16'd1; idx_mem[2] = 16'd2;
    vx_mem[0] = 16'd10; vx_mem[1] = 16'd20; vx_mem[2] = 16'd30;
    got_q.delete(); wr_cyc_q.delete();
    b0 = busy_cnt;
    start_run(1, 16'd0, 16'd0);
    wait_done(100, "basic");
    check("basic_writes", got_q.size(), 3);
    check("basic_x0", got_q[0][103:88], 16'd10);
    check("basic_gap01", wr_cyc_q[1] - wr_cyc_q[0], 5);
    check("basic_gap12", wr_cyc_q[2] - wr_cyc_q[1], 5);
    check("basic_done_lat", done_cyc - wr_cyc_q[2], 1);
    check("basic_busy_cycles", busy_cnt - b0, 16);

    // Back-pressure: full held for 7 cycles at the second PUSH.
    for (int a = 0; a < 3; a++) idx_mem[a] = 16'($urandom_range(0, 4095));
    got_q.delete(); wr_cyc_q.delete();
    wr0 = wr_cnt;
    start_run(1, 16'($urandom), 16'($urandom));
    wait_state(ST_PUSH, wr0 + 1, 50, "full_reach_push2");
    full_force = 1'b1;
    cycles(7);
    full_force = 1'b0;
    wait_done(100, "full");
    check("full_writes", wr_cnt - wr0, 3);
    check("full_gap01", wr_cyc_q[1] - wr_cyc_q[0], 12);

    // Saturation: positive and negative clamps, y reaching zero; runs back to back.
    idx_mem[0] = 16'd7; idx_mem[1] = 16'd8; idx_mem[2] = 16'd9;
    vx_mem[7] = 16'd32700; vy_mem[7] = 16'hfffb;
    got_q.delete();
    start_run(1, 16'd100, 16'd5);
    wait_done(100, "sat_pos");
    check("sat_pos_x", got_q[0][103:88], 16'h7fff);
    check("sat_y_zero", got_q[0][87:72], 16'h0000);
    vx_mem[7] = 16'h8044;
    got_q.delete();
    start_run(1, 16'hff9c, 16'd0);
    wait_done(100, "sat_neg");
    check("sat_neg_x", got_q[0][103:88], 16'h8000);

    // Zero triangles: done one cycle after start, busy for exactly the start cycle.
    cycles(2);
    wr0 = wr_cnt; ir0 = idx_rd_cnt; vr0 = vtx_rd_cnt; b0 = busy_cnt; s0 = cyc;
    start_run(0, 16'd0, 16'd0);
    wait_done(10, "zero");
    check("zero_done_lat", done_cyc - s0, 1);
    check("zero_strobes", (wr_cnt - wr0) + (idx_rd_cnt - ir0) + (vtx_rd_cnt - vr0), 0);
    check("zero_busy_cycles", busy_cnt - b0, 1);

    // Repeated index plus an ignored mid-run start.
    idx_mem[0] = 16'd3; idx_mem[1] = 16'd3; idx_mem[2] = 16'd4;
    idx_mem[3] = 16'd5; idx_mem[4] = 16'd0; idx_mem[5] = 16'd1;
    wr0 = wr_cnt; ir0 = idx_rd_cnt; vr0 = vtx_rd_cnt; d0 = done_cnt;
    start_run(2, 16'($urandom), 16'($urandom));
    cycles(12);
    i_tri_count = 16'd7; i_start = 1'b1;
    cycles(1);
    i_start = 1'b0;
    wait_done(200, "repeat");
    cycles(5);
    check("repeat_writes", wr_cnt - wr0, 6);
    check("repeat_idx_reads", idx_rd_cnt - ir0, 6);
    check("repeat_vtx_reads", vtx_rd_cnt - vr0, 6);
    check("repeat_done_once", done_cnt - d0, 1);

    // Reset during VTX_RD of the second vertex, then a clean restart.
    for (int a = 0; a < 6; a++) idx_mem[a] = 16'($urandom);
    wr0 = wr_cnt;
    start_run(2, 16'($urandom), 16'($urandom));
    wait_state(ST_VTX_RD, wr0 + 1, 50, "rst_reach_vtx_rd");
    i_rst = 1'b1;
    exp_q.delete(); exp_idx_q.delete(); exp_vtx_q.delete();
    wr0 = wr_cnt; ir0 = idx_rd_cnt; vr0 = vtx_rd_cnt; d0 = done_cnt;
    cycles(2);
    i_rst = 1'b0;
    cycles(5);
    check("rst_mid_strobes", (wr_cnt - wr0) + (idx_rd_cnt - ir0) + (vtx_rd_cnt - vr0), 0);
    check("rst_mid_done", done_cnt - d0, 0);
    check("rst_mid_busy", o_busy, 0);
    wr0 = wr_cnt;
    start_run(1, 16'($urandom), 16'($urandom));
    wait_done(100, "after_rst");
    check("after_rst_writes", wr_cnt - wr0, 3);

    // Random runs with random back-pressure.
    full_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(1, 4);
      for (int a = 0; a < cnt * 3; a++) idx_mem[a] = 16'($urandom);
      wr0 = wr_cnt;
      start_run(cnt, 16'($urandom), 16'($urandom));
      wait_done(cnt * 3 * 40 + 50, "random");
      check("random_writes", wr_cnt - wr0, cnt * 3);
      cycles($urandom_range(0, 3));
    end
    full_mode = 1'b0;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
